// File: rtl/complex_batch_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : complex_batch_sequencer
// Brief   : Loads operand pairs into the complex unit's memory, then sweeps
//           them through the unit and streams tagged results with overflow.
// Revision: 1.0 - initial release
// =============================================================================
module complex_batch_sequencer #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        run_start,
    input  logic [4:0]  count,
    input  logic [1:0]  op_select,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_a,
    input  logic [9:0]  in_b,
    output logic        cu_write,
    output logic [4:0]  cu_address_A,
    output logic [4:0]  cu_address_B,
    output logic [9:0]  cu_op_A,
    output logic [9:0]  cu_op_B,
    output logic [1:0]  cu_select,
    input  logic [21:0] cu_result,
    input  logic        cu_overflow_real,
    input  logic        cu_overflow_imaginary,
    output logic        out_valid,
    output logic [3:0]  out_index,
    output logic [21:0] out_result,
    output logic        out_ovf_real,
    output logic        out_ovf_imag,
    output logic [4:0]  ovf_count,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q;
    logic [4:0]  n_q;
    logic        cu_write_q;
    logic [4:0]  addr_a_q, addr_b_q;
    logic [9:0]  op_a_q, op_b_q;
    logic [1:0]  sel_q;
    logic        out_valid_q;
    logic [3:0]  out_index_q;
    logic [21:0] out_result_q;
    logic        out_ovf_real_q, out_ovf_imag_q;
    logic [4:0]  ovf_count_q;
    logic        done_q;
    logic [LAT:0] tag_v_q;
    logic [3:0]  tag_idx_q [LAT+1];

    logic        w_last;
    logic        w_accept;
    logic        w_run_go;
    logic        w_issue_next;
    logic        w_pipe_busy;
    logic        w_capture;
    logic [4:0]  w_n;

    assign w_n          = (count == 5'd0 || count > 5'd16) ? 5'd16 : count;
    assign w_last       = ({1'b0, idx_q} == (n_q - 5'd1));
    assign w_accept     = in_valid & in_ready;
    assign w_run_go     = (state_q == S_IDLE) && !load_start && run_start;
    assign w_issue_next = (state_q == S_RUN) && !w_last;
    // Stage LAT is being captured this cycle, so it does not hold DRAIN open.
    assign w_pipe_busy  = |tag_v_q[LAT-1:0];
    assign w_capture    = tag_v_q[LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start)     state_d = S_LOAD;
                else if (run_start) state_d = S_RUN;
            end
            S_LOAD:  if (w_accept && w_last) state_d = S_DONE;
            S_RUN:   if (w_last)             state_d = S_DRAIN;
            S_DRAIN: if (!w_pipe_busy)       state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // done is registered one cycle behind DONE, so busy is extended to cover it.
    always_comb begin
        in_ready = (state_q == S_LOAD);
        busy     = (state_q != S_IDLE) | done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= 4'd0;
            n_q        <= 5'd0;
            cu_write_q <= 1'b0;
            addr_a_q   <= 5'd0;
            addr_b_q   <= 5'd0;
            op_a_q     <= 10'd0;
            op_b_q     <= 10'd0;
            sel_q      <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            cu_write_q <= 1'b0;
            done_q     <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (load_start || run_start) begin
                        idx_q <= 4'd0;
                        n_q   <= w_n;
                    end
                    if (w_run_go) begin
                        sel_q    <= op_select;
                        addr_a_q <= 5'd0;
                        addr_b_q <= 5'd16;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        cu_write_q <= 1'b1;
                        addr_a_q   <= {1'b0, idx_q};
                        addr_b_q   <= {1'b1, idx_q};
                        op_a_q     <= in_a;
                        op_b_q     <= in_b;
                        idx_q      <= idx_q + 4'd1;
                    end
                end
                S_RUN: begin
                    if (w_issue_next) begin
                        idx_q    <= idx_q + 4'd1;
                        addr_a_q <= {1'b0, idx_q + 4'd1};
                        addr_b_q <= {1'b1, idx_q + 4'd1};
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag stage 0 travels with the address currently presented to the unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int s = 0; s <= LAT; s++) tag_idx_q[s] <= 4'd0;
        end else begin
            tag_v_q[0]   <= w_run_go | w_issue_next;
            tag_idx_q[0] <= w_run_go ? 4'd0 : idx_q + 4'd1;
            for (int s = 1; s <= LAT; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_index_q    <= 4'd0;
            out_result_q   <= 22'd0;
            out_ovf_real_q <= 1'b0;
            out_ovf_imag_q <= 1'b0;
            ovf_count_q    <= 5'd0;
        end else begin
            out_valid_q <= w_capture;
            if (w_capture) begin
                out_index_q    <= tag_idx_q[LAT];
                out_result_q   <= cu_result;
                out_ovf_real_q <= cu_overflow_real;
                out_ovf_imag_q <= cu_overflow_imaginary;
                if ((cu_overflow_real || cu_overflow_imaginary) && ovf_count_q != 5'd16)
                    ovf_count_q <= ovf_count_q + 5'd1;
            end
            if (w_run_go) ovf_count_q <= 5'd0;
        end
    end

    assign cu_write     = cu_write_q;
    assign cu_address_A = addr_a_q;
    assign cu_address_B = addr_b_q;
    assign cu_op_A      = op_a_q;
    assign cu_op_B      = op_b_q;
    assign cu_select    = sel_q;
    assign out_valid    = out_valid_q;
    assign out_index    = out_index_q;
    assign out_result   = out_result_q;
    assign out_ovf_real = out_ovf_real_q;
    assign out_ovf_imag = out_ovf_imag_q;
    assign ovf_count    = ovf_count_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_batch_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : tb_complex_batch_sequencer
// Brief   : Scoreboard bench with a LAT=2 model of the complex unit.
// Revision: 1.0 - initial release
// =============================================================================
module tb_complex_batch_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0, run_start = 1'b0;
    logic [4:0]  count = 5'd0;
    logic [1:0]  op_select = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_a = 10'd0, in_b = 10'd0;
    logic        cu_write;
    logic [4:0]  cu_address_A, cu_address_B;
    logic [9:0]  cu_op_A, cu_op_B;
    logic [1:0]  cu_select;
    logic [21:0] cu_result;
    logic        cu_overflow_real, cu_overflow_imaginary;
    logic        out_valid;
    logic [3:0]  out_index;
    logic [21:0] out_result;
    logic        out_ovf_real, out_ovf_imag;
    logic [4:0]  ovf_count;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    complex_batch_sequencer #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .run_start(run_start),
        .count(count), .op_select(op_select), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cu_write(cu_write), .cu_address_A(cu_address_A),
        .cu_address_B(cu_address_B), .cu_op_A(cu_op_A), .cu_op_B(cu_op_B),
        .cu_select(cu_select), .cu_result(cu_result), .cu_overflow_real(cu_overflow_real),
        .cu_overflow_imaginary(cu_overflow_imaginary), .out_valid(out_valid),
        .out_index(out_index), .out_result(out_result), .out_ovf_real(out_ovf_real),
        .out_ovf_imag(out_ovf_imag), .ovf_count(ovf_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Unit model: 32-entry operand memory, result = {2'b0, A, B} two cycles after address.
    logic [9:0]  mem [32];
    logic [21:0] p1_res, p2_res;
    logic        p1_ovr, p1_ovi, p2_ovr, p2_ovi;
    bit          ovf_on = 1'b0;

    initial for (int i = 0; i < 32; i++) mem[i] = 10'd0;

    always @(posedge clk) begin
        if (cu_write) begin
            mem[cu_address_A] <= cu_op_A;
            mem[cu_address_B] <= cu_op_B;
        end
        p1_res <= {2'b00, mem[cu_address_A], mem[cu_address_B]};
        p1_ovr <= ovf_on && (cu_address_A == 5'd1);
        p1_ovi <= ovf_on && (cu_address_A == 5'd3);
        p2_res <= p1_res;
        p2_ovr <= p1_ovr;
        p2_ovi <= p1_ovi;
    end
    assign cu_result             = p2_res;
    assign cu_overflow_real      = p2_ovr;
    assign cu_overflow_imaginary = p2_ovi;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: {addrA, addrB, opA, opB} and {index, result, ovr, ovi}.
    logic [29:0] wq [$];
    logic [27:0] outq [$];

    always @(negedge clk) begin
        if (cu_write === 1'b1) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr", {2'b0, cu_address_A, cu_address_B, cu_op_A, cu_op_B}, {2'b0, wq.pop_front()});
        end
        if (out_valid === 1'b1) begin
            if (outq.size() == 0) chk("out_unexpected", 1, 0);
            else chk("out", {4'b0, out_index, out_result, out_ovf_real, out_ovf_imag}, {4'b0, outq.pop_front()});
        end
    end

    logic [9:0] sa [16], sb [16];
    logic [9:0] ea [16], eb [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] cnt, input bit gaps, input bit both);
        int ne;
        ne = (cnt == 5'd0 || cnt > 5'd16) ? 16 : int'(cnt);
        count = cnt; load_start = 1'b1; run_start = both;
        tick;
        load_start = 1'b0; run_start = 1'b0;
        chk("load_busy", busy, 1);
        for (int k = 0; k < ne; k++) begin
            chk("load_rdy", in_ready, 1);
            in_valid = 1'b1; in_a = sa[k]; in_b = sb[k];
            wq.push_back({5'(k), 5'(k + 16), sa[k], sb[k]});
            ea[k] = sa[k]; eb[k] = sb[k];
            tick;
            in_valid = 1'b0;
            if (gaps && k != ne - 1) begin
                chk("gap_rdy", in_ready, 1);
                tick;
            end
        end
        chk("load_rdy_drop", in_ready, 0);
        chk("load_done_early", done, 0);
        tick;
        chk("load_done", done, 1);
        chk("load_busy_done", busy, 1);
        tick;
        chk("load_done_clr", done, 0);
        chk("load_idle", busy, 0);
        chk("wq_empty", wq.size(), 0);
    endtask

    task automatic do_run(input logic [4:0] cnt, input logic [1:0] sel, input bit ovf);
        int ne, nov, lastc;
        logic ovr, ovi;
        ne = (cnt == 5'd0 || cnt > 5'd16) ? 16 : int'(cnt);
        nov = 0;
        lastc = 2 + ne + LAT;
        for (int i = 0; i < ne; i++) begin
            ovr = ovf && (i == 1);
            ovi = ovf && (i == 3);
            if (ovr || ovi) nov++;
            outq.push_back({4'(i), 2'b00, ea[i], eb[i], ovr, ovi});
        end
        ovf_on = ovf; count = cnt; op_select = sel; run_start = 1'b1;
        tick;
        run_start = 1'b0;
        for (int c = 1; c <= lastc + 1; c++) begin
            if (c <= ne) begin
                chk("run_addrA", cu_address_A, c - 1);
                chk("run_addrB", cu_address_B, c + 15);
                chk("run_sel", cu_select, sel);
                chk("run_nowr", cu_write, 0);
            end
            chk("run_oval", out_valid, (c >= 2 + LAT && c < 2 + LAT + ne));
            chk("run_done", done, c == lastc);
            chk("run_busy", busy, c <= lastc);
            if (c == lastc) chk("ovf_count", ovf_count, nov);
            tick;
        end
        chk("outq_empty", outq.size(), 0);
        ovf_on = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("idle_outs", |{in_ready, cu_write, cu_address_A, cu_address_B, cu_op_A, cu_op_B,
                               cu_select, out_valid, out_index, out_result, out_ovf_real,
                               out_ovf_imag, ovf_count, done}, 0);
            chk("idle_busy", busy, 0);
            tick;
        end

        sa[0] = 10'sd5;    sb[0] = -10'sd3;
        sa[1] = 10'sd100;  sb[1] = 10'sd7;
        sa[2] = -10'sd512; sb[2] = 10'sd511;
        do_load(5'd3, 1'b0, 1'b0);
        do_run(5'd3, 2'd2, 1'b0);

        for (int k = 0; k < 16; k++) begin
            sa[k] = 10'($urandom);
            sb[k] = 10'($urandom);
        end
        do_load(5'd0, 1'b1, 1'b0);
        do_run(5'd0, 2'd1, 1'b0);

        sa[0] = 10'h155; sb[0] = 10'h2AA;
        sa[1] = 10'h3FF; sb[1] = 10'h001;
        do_load(5'd2, 1'b0, 1'b1);
        do_run(5'd4, 2'd3, 1'b1);

        count = 5'd4; op_select = 2'd1; run_start = 1'b1;
        tick;
        run_start = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        outq.delete();
        tick;
        reset = 1'b0;
        chk("rst_outs", |{in_ready, cu_write, cu_address_A, cu_address_B, cu_op_A, cu_op_B,
                          cu_select, out_valid, out_index, out_result, out_ovf_real,
                          out_ovf_imag, ovf_count, done}, 0);
        chk("rst_busy", busy, 0);
        for (int c = 0; c < 8; c++) begin
            tick;
            chk("rst_no_oval", out_valid, 0);
            chk("rst_no_done", done, 0);
            chk("rst_idle", busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
